// File: rtl/dec_pkg.sv
// rtl/dec_pkg.sv - shared FSM state, mode encodings and one-hot helper for seq_onehot_decoder
package dec_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_e;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   localparam int MAX_SEL_W = 6;
   localparam int MAX_OUT_W = 1 << MAX_SEL_W;

   function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
      onehot = MAX_OUT_W'(1) << idx;
   endfunction

endpackage

// File: rtl/dwell_counter.sv
// rtl/dwell_counter.sv - loadable down-counter with zero flag; holds at zero
module dwell_counter #(
   parameter int DWELL_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_i,
   input  logic [DWELL_W-1:0] load_val_i,
   input  logic               dec_i,
   output logic               zero_o
);

   logic [DWELL_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/seq_onehot_decoder.sv
// rtl/seq_onehot_decoder.sv - registered binary-to-one-hot decoder with optional scan walk
// Scan mode, busy/done and dwell logic exist only when DEC_SCAN_EN is defined.
module seq_onehot_decoder
   import dec_pkg::*;
#(
   parameter int SEL_W   = 3,
   parameter int DWELL_W = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [SEL_W-1:0]        inp,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    mode,
   input  logic [DWELL_W-1:0]      dwell,
   output logic [(1<<SEL_W)-1:0]   out,
   output logic                    out_valid,
   output logic                    busy,
   output logic                    done
);

   localparam int OUT_W = 1 << SEL_W;

   logic [OUT_W-1:0] out_q, out_d;
   logic             out_valid_q;

   assign out_d     = OUT_W'(onehot(MAX_SEL_W'(inp)));
   assign out       = out_q;
   assign out_valid = out_valid_q;

`ifdef DEC_SCAN_EN

   state_e             state_q;
   logic [SEL_W-1:0]   step_q;
   logic [DWELL_W-1:0] dwell_q;
   logic               busy_q, done_q;
   logic               cnt_zero, cnt_load, step_last, start_scan;

   assign in_ready   = (state_q == IDLE);
   assign busy       = busy_q;
   assign done       = done_q;
   assign step_last  = &step_q;
   assign start_scan = (state_q == IDLE) && in_valid && (mode == MODE_SCAN);

   // Reload on scan start (fresh dwell) and on every position advance (latched dwell).
   assign cnt_load = start_scan || ((state_q == SCAN) && cnt_zero && !step_last);

   dwell_counter #(
      .DWELL_W (DWELL_W)
   ) u_dwell_counter (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cnt_load),
      .load_val_i ((state_q == IDLE) ? dwell : dwell_q),
      .dec_i      (state_q == SCAN),
      .zero_o     (cnt_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         step_q      <= '0;
         dwell_q     <= '0;
      end else begin
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  out_q       <= out_d;
                  out_valid_q <= 1'b1;
                  if (mode == MODE_SCAN) begin
                     state_q <= SCAN;
                     busy_q  <= 1'b1;
                     dwell_q <= dwell;
                     step_q  <= '0;
                  end
               end
            end
            SCAN: begin
               if (cnt_zero) begin
                  if (!step_last) begin
                     out_q       <= {out_q[OUT_W-2:0], out_q[OUT_W-1]};
                     step_q      <= step_q + SEL_W'(1);
                     out_valid_q <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                     out_q   <= '0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`else

   logic unused_scan_inputs;
   assign unused_scan_inputs = ^{mode, dwell};

   assign in_ready = 1'b1;
   assign busy     = 1'b0;
   assign done     = 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= in_valid;
         if (in_valid) begin
            out_q <= out_d;
         end
      end
   end

`endif

endmodule

// File: tb/tb_seq_onehot_decoder.sv
// tb/tb_seq_onehot_decoder.sv - directed self-checking bench for seq_onehot_decoder (both DEC_SCAN_EN builds)
module tb_seq_onehot_decoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic [2:0]  inp = '0;
   logic        in_valid = 1'b0;
   logic        mode = 1'b0;
   logic [3:0]  dwell = '0;
   logic        in_ready;
   logic [7:0]  out;
   logic        out_valid, busy, done;

   logic [3:0]  inp4 = '0;
   logic        in_valid4 = 1'b0;
   logic        mode4 = 1'b0;
   logic [3:0]  dwell4 = '0;
   logic        in_ready4;
   logic [15:0] out4;
   logic        out_valid4, busy4, done4;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   seq_onehot_decoder #(.SEL_W(3), .DWELL_W(4)) u_dut3 (
      .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .dwell(dwell), .out(out), .out_valid(out_valid),
      .busy(busy), .done(done)
   );

   seq_onehot_decoder #(.SEL_W(4), .DWELL_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .inp(inp4), .in_valid(in_valid4), .in_ready(in_ready4),
      .mode(mode4), .dwell(dwell4), .out(out4), .out_valid(out_valid4),
      .busy(busy4), .done(done4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out"}, 32'(out), 32'h0);
      check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
      check({tag, "_busy"}, 32'(busy), 32'h0);
      check({tag, "_done"}, 32'(done), 32'h0);
      check({tag, "_in_ready"}, 32'(in_ready), 32'h1);
   endtask

   logic [7:0] sweep_exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
`ifdef DEC_SCAN_EN
   logic [7:0] scan5_exp [8] = '{8'h20, 8'h40, 8'h80, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
`endif

   initial begin
      int pulses;

      tick();
      tick();
      check_reset_outputs("reset_init");
      rst = 1'b0;

      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         inp = 3'(i);
         in_valid = 1'b1;
         mode = 1'b0;
         tick();
         check($sformatf("sweep_out_%0d", i), 32'(out), 32'(sweep_exp[i]));
         if (out_valid) pulses++;
      end
      in_valid = 1'b0;
      check("sweep_pulses", 32'(pulses), 32'd8);
      tick();
      check("hold_out", 32'(out), 32'h80);
      check("hold_out_valid", 32'(out_valid), 32'h0);

      inp = 3'd3;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("pre_rst_out", 32'(out), 32'h08);
      #2 rst = 1'b1;
      #1 check_reset_outputs("async_rst");
      #2 rst = 1'b0;

`ifdef DEC_SCAN_EN
      inp = 3'd5;
      mode = 1'b1;
      dwell = 4'd2;
      in_valid = 1'b1;
      tick();
      check("scan_c0_out", 32'(out), 32'h20);
      check("scan_c0_valid", 32'(out_valid), 32'h1);
      check("scan_c0_busy", 32'(busy), 32'h1);
      check("scan_c0_ready", 32'(in_ready), 32'h0);
      inp = 3'd1;
      mode = 1'b0;
      for (int c = 1; c < 24; c++) begin
         tick();
         check($sformatf("scan_c%0d_out", c), 32'(out), 32'(scan5_exp[c/3]));
         check($sformatf("scan_c%0d_valid", c), 32'(out_valid), (c % 3 == 0) ? 32'h1 : 32'h0);
         check($sformatf("scan_c%0d_done", c), 32'(done), 32'h0);
      end
      tick();
      check("scan_end_out", 32'(out), 32'h0);
      check("scan_end_done", 32'(done), 32'h1);
      check("scan_end_valid", 32'(out_valid), 32'h0);
      check("scan_end_busy", 32'(busy), 32'h0);
      check("scan_end_ready", 32'(in_ready), 32'h1);
      tick();
      check("post_scan_out", 32'(out), 32'h02);
      check("post_scan_valid", 32'(out_valid), 32'h1);
      check("post_scan_done", 32'(done), 32'h0);
      in_valid = 1'b0;

      inp = 3'd0;
      mode = 1'b1;
      dwell = 4'd1;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("scan2_start", 32'(out), 32'h01);
      for (int c = 0; c < 6; c++) tick();
      check("scan2_step3_out", 32'(out), 32'h08);
      check("scan2_step3_busy", 32'(busy), 32'h1);
      #2 rst = 1'b1;
      #1 check_reset_outputs("midscan_rst");
      #2 rst = 1'b0;
      inp = 3'd6;
      mode = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("after_rst_out", 32'(out), 32'h40);
      check("after_rst_valid", 32'(out_valid), 32'h1);

      inp4 = 4'd15;
      mode4 = 1'b1;
      dwell4 = 4'd0;
      in_valid4 = 1'b1;
      tick();
      in_valid4 = 1'b0;
      check("w16_c0_out", 32'(out4), 32'h8000);
      for (int c = 1; c < 16; c++) begin
         tick();
         check($sformatf("w16_c%0d_out", c), 32'(out4), 32'h1 << (c - 1));
         check($sformatf("w16_c%0d_valid", c), 32'(out_valid4), 32'h1);
      end
      tick();
      check("w16_end_out", 32'(out4), 32'h0);
      check("w16_end_done", 32'(done4), 32'h1);
      check("w16_end_ready", 32'(in_ready4), 32'h1);
`else
      inp = 3'd4;
      mode = 1'b1;
      dwell = 4'd5;
      in_valid = 1'b1;
      tick();
      check("noscan_out", 32'(out), 32'h10);
      check("noscan_valid", 32'(out_valid), 32'h1);
      check("noscan_busy", 32'(busy), 32'h0);
      check("noscan_ready", 32'(in_ready), 32'h1);
      inp = 3'd7;
      tick();
      in_valid = 1'b0;
      check("noscan_b2b_out", 32'(out), 32'h80);
      check("noscan_done", 32'(done), 32'h0);

      inp4 = 4'd15;
      mode4 = 1'b1;
      in_valid4 = 1'b1;
      tick();
      in_valid4 = 1'b0;
      check("noscan16_out", 32'(out4), 32'h8000);
      check("noscan16_busy", 32'(busy4), 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
